// File: rtl/disp_share_arb_if.sv
// Requester/display-driver bundle for the shared seven-segment display arbiter.
// Requesters drive req/dat/ptr as master; the arbiter drives grant and routed data as slave.
interface disp_share_arb_if;
   logic [2:0]  req;
   logic [15:0] dat0;
   logic [15:0] dat1;
   logic [15:0] dat2;
   logic [2:0]  ptr;
   logic [2:0]  gnt;
   logic [1:0]  src;
   logic [15:0] disp_dat;
   logic        disp_ptr;
   logic        busy;

   modport master (
      output req, dat0, dat1, dat2, ptr,
      input  gnt, src, disp_dat, disp_ptr, busy
   );

   modport slave (
      input  req, dat0, dat1, dat2, ptr,
      output gnt, src, disp_dat, disp_ptr, busy
   );
endinterface

// File: rtl/disp_share_arb.sv
// Rotating-priority time-sharing arbiter for the 4-digit display, with a minimum
// dwell per grant counted in display 1-second ticks.
module disp_share_arb #(
   parameter int DWELL = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce1s,
   disp_share_arb_if.slave  bus
);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t      state;
   logic [1:0]  last;
   logic [3:0]  dwell;
   logic [3:0]  dwell_nx;
   logic        win_found;
   logic [1:0]  win_idx;
   logic [1:0]  cand1;
   logic [1:0]  cand2;
   logic        take_grant;
   logic        go_idle;
   logic [15:0] sel_dat;
   logic        sel_ptr;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search order is last+1, last+2, then last itself, so the current owner
   // only wins again when nobody else is asking.
   always_comb begin
      cand1     = next_idx(last);
      cand2     = next_idx(cand1);
      win_found = 1'b1;
      win_idx   = last;
      if (bus.req[cand1])
         win_idx = cand1;
      else if (bus.req[cand2])
         win_idx = cand2;
      else if (bus.req[last])
         win_idx = last;
      else
         win_found = 1'b0;
   end

   // Expiry looks at the post-tick count so the rotation lands the cycle after
   // the tick that takes dwell from 1 to 0.
   always_comb begin
      dwell_nx   = (ce1s && (dwell != 4'd0)) ? dwell - 4'd1 : dwell;
      take_grant = 1'b0;
      go_idle    = 1'b0;
      if (state == IDLE) begin
         take_grant = win_found;
      end else if (!bus.req[bus.src]) begin
         take_grant = win_found;
         go_idle    = !win_found;
      end else if ((dwell_nx == 4'd0) && (win_idx != bus.src)) begin
         take_grant = 1'b1;
      end
   end

   always_comb begin
      sel_dat = bus.dat2;
      sel_ptr = bus.ptr[2];
      case (bus.src)
         2'd0: begin
            sel_dat = bus.dat0;
            sel_ptr = bus.ptr[0];
         end
         2'd1: begin
            sel_dat = bus.dat1;
            sel_ptr = bus.ptr[1];
         end
         default: begin
            sel_dat = bus.dat2;
            sel_ptr = bus.ptr[2];
         end
      endcase
   end

   // Display data is only refreshed while a grant is live, so the digits keep
   // the last shown value through idle periods.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last         <= 2'd2;
         dwell        <= 4'd0;
         bus.gnt      <= 3'b000;
         bus.src      <= 2'd0;
         bus.busy     <= 1'b0;
         bus.disp_dat <= 16'h0000;
         bus.disp_ptr <= 1'b0;
      end else begin
         if (state == SHOW) begin
            bus.disp_dat <= sel_dat;
            bus.disp_ptr <= sel_ptr;
         end
         if (take_grant) begin
            state    <= SHOW;
            last     <= win_idx;
            dwell    <= 4'(DWELL);
            bus.gnt  <= 3'b001 << win_idx;
            bus.src  <= win_idx;
            bus.busy <= 1'b1;
         end else if (go_idle) begin
            state    <= IDLE;
            dwell    <= 4'd0;
            bus.gnt  <= 3'b000;
            bus.busy <= 1'b0;
         end else if (state == SHOW) begin
            dwell <= dwell_nx;
         end
      end
   end

endmodule

// File: doc/disp_share_arb.md
# disp_share_arb

Time-sharing arbiter for the 4-digit seven-segment display driver in the ADC lab design. Three requesters (for example raw ADC code, scaled voltage and a sample counter) each present a 16-bit hex value and a decimal-point select. The block grants the display to one requester at a time using rotating priority, and guarantees a minimum dwell measured in display 1-second ticks. It sits between the requesters and the display driver and consumes the driver's `ce1s` pulse.

## Interface
Parameters:
- `DWELL`, default 3: minimum grant length in `ce1s` pulses; legal range 1..15.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `ce1s`, in, 1: one-cycle pulse, once per second, from the display driver.
- `req`, in, 3: request per source; level, held while the source wants the display.
- `dat0`, `dat1`, `dat2`, in, 16 each: value for source 0/1/2.
- `ptr`, in, 3: decimal-point select per source; passed through unchanged as the driver's `PTR`.
- `gnt`, out, 3: one-hot grant, or all zero.
- `src`, out, 2: index of the current or last granted source.
- `disp_dat`, out, 16: value routed to the display driver `dat`.
- `disp_ptr`, out, 1: routed to the display driver `PTR`.
- `busy`, out, 1: high whenever `gnt` is not zero.

## Operation
- States:
  - IDLE: `gnt`=0.
  - SHOW: exactly one `gnt` bit is set.
- Round-robin pointer `last` (2 bits) holds the most recently granted index. Priority search order is `last+1`, `last+2`, `last+3` mod 3. Reset value of `last` is 2, so source 0 wins first.
- IDLE -> SHOW: taken when any `req` bit is set. The winner is picked by the search order; `gnt`/`src` are set and `last` is updated to the winner; `dwell` is loaded with `DWELL`.
- Dwell counter `dwell` (4 bits):
  - Decrements on each `ce1s` while in SHOW and nonzero.
  - Expired when it equals 0.
  - Any `ce1s` pulse after the grant cycle counts, so real dwell is (DWELL-1, DWELL] seconds.
- SHOW, granted `req` drops (any dwell value): the grant ends immediately. The search runs over the remaining requests; if there is a winner, go directly to that source (new grant, `dwell` reloaded); otherwise go to IDLE. Dwell never holds a released grant.
- SHOW, dwell expired, another `req` set: rotate to the next requester in search order, `dwell` reloaded. There is no idle gap.
- SHOW, dwell expired, only the granted `req` set: keep the grant. `dwell` stays 0, and the block rotates on the first cycle any other request appears.
- SHOW, dwell not expired: other requests wait.
- Data path:
  - While in SHOW, `disp_dat`/`disp_ptr` track `dat[src]`/`ptr[src]` every cycle through a register.
  - In IDLE they hold the last shown values, so the display never blanks between grants.
- `src` holds its last value in IDLE.
- Reset values: `gnt`=0, `busy`=0, `src`=0, `disp_dat`=16'h0000, `disp_ptr`=0, `dwell`=0, `last`=2, state IDLE.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Grant latency: a request set in cycle t gives `gnt` in cycle t+1 and `disp_dat` = `dat` sampled in cycle t+1 valid in cycle t+2.
- Release latency: `req` dropped in cycle t gives the `gnt` bit cleared, or switched to the next source, in cycle t+1.
- `ce1s` and expiry in the same cycle as the granted `req` dropping: the release rule applies, then the search.
- `ce1s` in the cycle `dwell` goes 1->0: rotation, if eligible, is visible in the following cycle.
- A `ce1s` arriving during IDLE is ignored.
- A `ce1s` arriving in the grant cycle itself does not decrement `dwell`.
- `rst` has priority over every other event, including `ce1s` and `req`, in the same cycle. A reset mid-grant returns all outputs to their reset values in the next cycle.
- `gnt` is never more than one-hot; it goes from one source to another in a single cycle.

## Test plan
- Reset, then `req`=3'b111 at cycle 5 -> `gnt`=3'b001 at cycle 6, `src`=0. After 3 `ce1s` pulses, `gnt`=3'b010 the cycle after the third pulse; after 3 more, `gnt`=3'b100; then back to 3'b001.
- Single request: `req`=3'b010, `dat1`=16'h1234, `ptr`[1]=1 -> `gnt`=3'b010; `disp_dat`=16'h1234 and `disp_ptr`=1 one cycle later. Change `dat1` to 16'hABCD -> `disp_dat` follows one cycle later. Ten `ce1s` pulses -> grant kept.
- Early release: source 0 granted, `req`[2] pending, `req`[0] dropped before the first `ce1s` -> next cycle `gnt`=3'b100 with `dwell`=3. Drop all `req` -> IDLE; `disp_dat` keeps source 2's last value.
- Preemption wait: `gnt`=3'b001, `req`[1] raised after 1 `ce1s` -> `gnt` stays 3'b001 until the cycle after the third `ce1s`, then becomes 3'b010.
- Simultaneous events: `ce1s`=1 in the expiry cycle together with `req`[0] falling and `req`=3'b110 -> `gnt`=3'b010 next cycle, `last`=1.
- Reset mid-grant: `rst`=1 while `gnt`=3'b100, `dwell`=2 and `ce1s`=1 -> next cycle all outputs are 0 and `last`=2. With `req`=3'b111, source 0 is granted first.
